// File: rtl/alu_stim_check_if.sv
// Bundle of every signal the checker exchanges with its command source, one ALU and a status monitor.
// The master modport is the checker's view; the slave modport is the view of the surrounding environment.
interface alu_stim_check_if #(
  parameter int WIDTH = 6
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic [1:0]       alu_op;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic             alu_valid;
  logic [WIDTH-1:0] res_in;
  logic             res_valid;
  logic [15:0]      pass_cnt;
  logic [15:0]      err_cnt;
  logic             err_flag;
  logic [WIDTH-1:0] last_exp;
  logic [WIDTH-1:0] last_got;
  logic             busy;
  logic             timeout;

  modport master (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, res_in, res_valid,
    output cmd_ready, alu_op, alu_a, alu_b, alu_valid,
    output pass_cnt, err_cnt, err_flag, last_exp, last_got, busy, timeout
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_a, cmd_b, res_in, res_valid,
    input  cmd_ready, alu_op, alu_a, alu_b, alu_valid,
    input  pass_cnt, err_cnt, err_flag, last_exp, last_got, busy, timeout
  );
endinterface

// File: rtl/alu_stim_check.sv
// Drives commands into an ALU, queues the result each command should produce and checks
// ALU responses in order, counting passes and errors and trapping responses that never arrive.
module alu_stim_check #(
  parameter int WIDTH   = 6,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 8
) (
  input  logic                clk,
  input  logic                rst,
  alu_stim_check_if.master    bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] FULL   = CW'(DEPTH);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ACTIVE, FAULT} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_queue [DEPTH];
  logic [PW-1:0]    r_wrPtr;
  logic [PW-1:0]    r_rdPtr;
  logic [CW-1:0]    r_count;
  logic [TW-1:0]    r_toCnt;
  logic [1:0]       r_aluOp;
  logic [WIDTH-1:0] r_aluA;
  logic [WIDTH-1:0] r_aluB;
  logic             r_aluValid;
  logic [15:0]      r_passCnt;
  logic [15:0]      r_errCnt;
  logic             r_errFlag;
  logic [WIDTH-1:0] r_lastExp;
  logic [WIDTH-1:0] r_lastGot;
  logic             r_timeout;

  logic             w_cmdReady;
  logic             w_accept;
  logic             w_pop;
  logic             w_toFire;
  logic [WIDTH-1:0] w_expected;
  logic [WIDTH-1:0] w_head;
  logic [CW-1:0]    w_countNext;
  logic [TW-1:0]    w_toNext;

  // Ready depends only on registered occupancy, so a pop frees a slot one cycle later.
  assign w_cmdReady = (r_count < FULL) && (r_state != FAULT);
  assign w_accept   = bus.cmd_valid && w_cmdReady;
  assign w_pop      = bus.res_valid && (r_count != '0);
  assign w_head     = r_queue[r_rdPtr];
  assign w_toNext   = r_toCnt + TW'(1);
  assign w_toFire   = !bus.res_valid && (r_count != '0) && (r_state != FAULT) && (w_toNext == TO_MAX);

  always_comb begin
    w_expected = '0;
    case (bus.cmd_op)
      2'h1:    w_expected = bus.cmd_a + bus.cmd_b;
      2'h2:    w_expected = bus.cmd_a - bus.cmd_b;
      default: w_expected = '0;
    endcase
  end

  always_comb begin
    w_countNext = r_count;
    if (w_accept && !w_pop) w_countNext = r_count + CW'(1);
    else if (w_pop && !w_accept) w_countNext = r_count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst && w_accept) r_queue[r_wrPtr] <= w_expected;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_toCnt    <= '0;
      r_aluOp    <= '0;
      r_aluA     <= '0;
      r_aluB     <= '0;
      r_aluValid <= 1'b0;
      r_passCnt  <= '0;
      r_errCnt   <= '0;
      r_errFlag  <= 1'b0;
      r_lastExp  <= '0;
      r_lastGot  <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_aluValid <= w_accept;
      if (w_accept) begin
        r_aluOp <= bus.cmd_op;
        r_aluA  <= bus.cmd_a;
        r_aluB  <= bus.cmd_b;
        r_wrPtr <= r_wrPtr + PW'(1);
      end
      if (w_pop) r_rdPtr <= r_rdPtr + PW'(1);
      r_count <= w_countNext;

      // An empty-queue response is reported against an expected value of zero.
      if (bus.res_valid) begin
        if (w_pop && (bus.res_in == w_head)) begin
          if (r_passCnt != 16'hFFFF) r_passCnt <= r_passCnt + 16'd1;
        end else begin
          if (r_errCnt != 16'hFFFF) r_errCnt <= r_errCnt + 16'd1;
          r_errFlag <= 1'b1;
          r_lastExp <= w_pop ? w_head : '0;
          r_lastGot <= bus.res_in;
        end
      end

      if (bus.res_valid || (r_count == '0)) r_toCnt <= '0;
      else if (r_state != FAULT) r_toCnt <= w_toNext;
      if (w_toFire) r_timeout <= 1'b1;

      case (r_state)
        FAULT:   r_state <= FAULT;
        default: begin
          if (w_toFire) r_state <= FAULT;
          else r_state <= (w_countNext != '0) ? ACTIVE : IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready = w_cmdReady;
  assign bus.alu_op    = r_aluOp;
  assign bus.alu_a     = r_aluA;
  assign bus.alu_b     = r_aluB;
  assign bus.alu_valid = r_aluValid;
  assign bus.pass_cnt  = r_passCnt;
  assign bus.err_cnt   = r_errCnt;
  assign bus.err_flag  = r_errFlag;
  assign bus.last_exp  = r_lastExp;
  assign bus.last_got  = r_lastGot;
  assign bus.busy      = (r_count != '0);
  assign bus.timeout   = r_timeout;
endmodule

// File: tb/tb_alu_stim_check.sv
// Directed bench for alu_stim_check: the bench plays both the command source and the ALU,
// answering with hand-computed results (or deliberately wrong ones).
module tb_alu_stim_check;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  alu_stim_check_if #(.WIDTH(6)) bus ();

  alu_stim_check #(.WIDTH(6), .DEPTH(4), .TIMEOUT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.res_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (bus.alu_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_alu_valid got=%0h exp=0", bus.alu_valid); end
    checks++; if (bus.pass_cnt !== 16'd0) begin failures++; $display("[TB] FAIL reset_pass_cnt got=%0h exp=0", bus.pass_cnt); end
    checks++; if (bus.err_cnt !== 16'd0) begin failures++; $display("[TB] FAIL reset_err_cnt got=%0h exp=0", bus.err_cnt); end
    checks++; if ({bus.err_flag, bus.busy, bus.timeout} !== 3'b000) begin failures++; $display("[TB] FAIL reset_flags got=%b exp=000", {bus.err_flag, bus.busy, bus.timeout}); end
    checks++; if ({bus.alu_op, bus.alu_a, bus.alu_b, bus.last_exp, bus.last_got} !== 26'd0) begin failures++; $display("[TB] FAIL reset_data got=%0h exp=0", {bus.alu_op, bus.alu_a, bus.alu_b, bus.last_exp, bus.last_got}); end
    rst = 1'b0;
    #1;
    checks++; if (bus.cmd_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_cmd_ready got=%0h exp=1", bus.cmd_ready); end
  endtask

  task automatic test_add_pass();
    do_reset();
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'h1; bus.cmd_a = 6'd5; bus.cmd_b = 6'd3;
    tick();
    bus.cmd_valid = 1'b0;
    checks++; if ({bus.alu_valid, bus.alu_op, bus.alu_a, bus.alu_b} !== {1'b1, 2'h1, 6'd5, 6'd3}) begin failures++; $display("[TB] FAIL add_issue got=%0h exp=%0h", {bus.alu_valid, bus.alu_op, bus.alu_a, bus.alu_b}, {1'b1, 2'h1, 6'd5, 6'd3}); end
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("[TB] FAIL add_busy got=%0h exp=1", bus.busy); end
    tick();
    checks++; if ({bus.alu_valid, bus.alu_a} !== {1'b0, 6'd5}) begin failures++; $display("[TB] FAIL add_single_pulse got=%0h exp=%0h", {bus.alu_valid, bus.alu_a}, {1'b0, 6'd5}); end
    bus.res_valid = 1'b1; bus.res_in = 6'd8;
    tick();
    bus.res_valid = 1'b0;
    checks++; if (bus.pass_cnt !== 16'd1) begin failures++; $display("[TB] FAIL add_pass_cnt got=%0h exp=1", bus.pass_cnt); end
    checks++; if (bus.err_cnt !== 16'd0) begin failures++; $display("[TB] FAIL add_err_cnt got=%0h exp=0", bus.err_cnt); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL add_busy_clear got=%0h exp=0", bus.busy); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'h2; bus.cmd_a = 6'd3; bus.cmd_b = 6'd5;
    tick();
    checks++; if ({bus.alu_valid, bus.alu_op, bus.alu_a, bus.alu_b} !== {1'b1, 2'h2, 6'd3, 6'd5}) begin failures++; $display("[TB] FAIL b2b_issue_sub got=%0h exp=%0h", {bus.alu_valid, bus.alu_op, bus.alu_a, bus.alu_b}, {1'b1, 2'h2, 6'd3, 6'd5}); end
    bus.cmd_op = 2'h1; bus.cmd_a = 6'd40; bus.cmd_b = 6'd30;
    tick();
    bus.cmd_valid = 1'b0;
    checks++; if ({bus.alu_valid, bus.alu_op, bus.alu_a, bus.alu_b} !== {1'b1, 2'h1, 6'd40, 6'd30}) begin failures++; $display("[TB] FAIL b2b_issue_add got=%0h exp=%0h", {bus.alu_valid, bus.alu_op, bus.alu_a, bus.alu_b}, {1'b1, 2'h1, 6'd40, 6'd30}); end
    bus.res_valid = 1'b1; bus.res_in = 6'h3E;
    tick();
    bus.res_in = 6'h06;
    tick();
    bus.res_valid = 1'b0;
    checks++; if (bus.pass_cnt !== 16'd2) begin failures++; $display("[TB] FAIL b2b_pass_cnt got=%0h exp=2", bus.pass_cnt); end
    checks++; if ({bus.err_cnt, bus.busy} !== {16'd0, 1'b0}) begin failures++; $display("[TB] FAIL b2b_err_busy got=%0h exp=0", {bus.err_cnt, bus.busy}); end
  endtask

  task automatic test_full_backpressure();
    int issued = 0;
    do_reset();
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'h0; bus.cmd_a = 6'd17; bus.cmd_b = 6'd9;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.alu_valid === 1'b1) issued++;
    end
    checks++; if (issued !== 4) begin failures++; $display("[TB] FAIL full_accepted got=%0d exp=4", issued); end
    checks++; if (bus.cmd_ready !== 1'b0) begin failures++; $display("[TB] FAIL full_cmd_ready got=%0h exp=0", bus.cmd_ready); end
    bus.res_valid = 1'b1; bus.res_in = 6'd0;
    tick();
    checks++; if ({bus.cmd_ready, bus.alu_valid} !== 2'b10) begin failures++; $display("[TB] FAIL full_ready_after_pop got=%b exp=10", {bus.cmd_ready, bus.alu_valid}); end
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.alu_valid === 1'b1) issued++;
      if (issued >= 6) bus.cmd_valid = 1'b0;
    end
    bus.res_valid = 1'b0;
    checks++; if (issued !== 6) begin failures++; $display("[TB] FAIL full_total_issued got=%0d exp=6", issued); end
    checks++; if (bus.pass_cnt !== 16'd6) begin failures++; $display("[TB] FAIL full_pass_cnt got=%0h exp=6", bus.pass_cnt); end
    checks++; if ({bus.err_cnt, bus.busy} !== {16'd0, 1'b0}) begin failures++; $display("[TB] FAIL full_err_busy got=%0h exp=0", {bus.err_cnt, bus.busy}); end
  endtask

  task automatic test_mismatch();
    do_reset();
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'h1; bus.cmd_a = 6'd4; bus.cmd_b = 6'd4;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    bus.res_valid = 1'b1; bus.res_in = 6'd9;
    tick();
    bus.res_valid = 1'b0;
    checks++; if ({bus.err_cnt, bus.err_flag} !== {16'd1, 1'b1}) begin failures++; $display("[TB] FAIL mis_err got=%0h exp=%0h", {bus.err_cnt, bus.err_flag}, {16'd1, 1'b1}); end
    checks++; if ({bus.last_exp, bus.last_got} !== {6'd8, 6'd9}) begin failures++; $display("[TB] FAIL mis_last got=%0h exp=%0h", {bus.last_exp, bus.last_got}, {6'd8, 6'd9}); end
    checks++; if (bus.pass_cnt !== 16'd0) begin failures++; $display("[TB] FAIL mis_pass_cnt got=%0h exp=0", bus.pass_cnt); end
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'h1; bus.cmd_a = 6'd1; bus.cmd_b = 6'd2;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    bus.res_valid = 1'b1; bus.res_in = 6'd3;
    tick();
    bus.res_valid = 1'b0;
    checks++; if ({bus.pass_cnt, bus.err_cnt, bus.err_flag} !== {16'd1, 16'd1, 1'b1}) begin failures++; $display("[TB] FAIL mis_recover got=%0h exp=%0h", {bus.pass_cnt, bus.err_cnt, bus.err_flag}, {16'd1, 16'd1, 1'b1}); end
  endtask

  task automatic test_unexpected();
    do_reset();
    bus.res_valid = 1'b1; bus.res_in = 6'h2A;
    tick();
    bus.res_valid = 1'b0;
    checks++; if ({bus.err_cnt, bus.err_flag} !== {16'd1, 1'b1}) begin failures++; $display("[TB] FAIL unexp_err got=%0h exp=%0h", {bus.err_cnt, bus.err_flag}, {16'd1, 1'b1}); end
    checks++; if ({bus.last_exp, bus.last_got} !== {6'h00, 6'h2A}) begin failures++; $display("[TB] FAIL unexp_last got=%0h exp=%0h", {bus.last_exp, bus.last_got}, {6'h00, 6'h2A}); end
    checks++; if ({bus.pass_cnt, bus.busy} !== {16'd0, 1'b0}) begin failures++; $display("[TB] FAIL unexp_pass_busy got=%0h exp=0", {bus.pass_cnt, bus.busy}); end
  endtask

  task automatic test_timeout_reset();
    int firstHigh = -1;
    do_reset();
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'h1; bus.cmd_a = 6'd7; bus.cmd_b = 6'd1;
    tick();
    bus.cmd_valid = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (firstHigh < 0 && bus.timeout === 1'b1) firstHigh = i;
    end
    checks++; if (firstHigh !== 8) begin failures++; $display("[TB] FAIL timeout_cycle got=%0d exp=8", firstHigh); end
    checks++; if ({bus.timeout, bus.cmd_ready, bus.busy} !== 3'b101) begin failures++; $display("[TB] FAIL timeout_state got=%b exp=101", {bus.timeout, bus.cmd_ready, bus.busy}); end
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'h2; bus.cmd_a = 6'd9; bus.cmd_b = 6'd4;
    tick();
    checks++; if (bus.alu_valid !== 1'b0) begin failures++; $display("[TB] FAIL fault_no_issue got=%0h exp=0", bus.alu_valid); end
    bus.res_valid = 1'b1; bus.res_in = 6'd8;
    tick();
    bus.res_valid = 1'b0;
    checks++; if ({bus.pass_cnt, bus.timeout, bus.busy} !== {16'd1, 1'b1, 1'b0}) begin failures++; $display("[TB] FAIL fault_still_checks got=%0h exp=%0h", {bus.pass_cnt, bus.timeout, bus.busy}, {16'd1, 1'b1, 1'b0}); end
    rst = 1'b1;
    tick();
    checks++; if ({bus.timeout, bus.busy, bus.err_flag, bus.alu_valid, bus.pass_cnt, bus.err_cnt} !== 36'd0) begin failures++; $display("[TB] FAIL fault_reset got=%0h exp=0", {bus.timeout, bus.busy, bus.err_flag, bus.alu_valid, bus.pass_cnt, bus.err_cnt}); end
    rst = 1'b0;
    tick();
    bus.cmd_valid = 1'b0;
    checks++; if ({bus.alu_valid, bus.alu_op, bus.alu_a, bus.alu_b, bus.busy} !== {1'b1, 2'h2, 6'd9, 6'd4, 1'b1}) begin failures++; $display("[TB] FAIL post_reset_accept got=%0h exp=%0h", {bus.alu_valid, bus.alu_op, bus.alu_a, bus.alu_b, bus.busy}, {1'b1, 2'h2, 6'd9, 6'd4, 1'b1}); end
    tick();
    bus.res_valid = 1'b1; bus.res_in = 6'd5;
    tick();
    bus.res_valid = 1'b0;
    checks++; if ({bus.pass_cnt, bus.err_cnt, bus.busy} !== {16'd1, 16'd0, 1'b0}) begin failures++; $display("[TB] FAIL post_reset_pass got=%0h exp=%0h", {bus.pass_cnt, bus.err_cnt, bus.busy}, {16'd1, 16'd0, 1'b0}); end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired got=running exp=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'h0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.res_valid = 1'b0;
    bus.res_in    = '0;
    test_reset();
    test_add_pass();
    test_back_to_back();
    test_full_backpressure();
    test_mismatch();
    test_unexpected();
    test_timeout_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
